mcycle_ctrl: RTL and testbench

MCYCLE_CTRL -- requirements
Module: mcycle_ctrl

---
 rtl/mcycle_pkg.sv | 67 ++++++
 rtl/mcycle_aludec.sv | 34 +++
 rtl/mcycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mcycle_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mcycle_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// FSM states, opcode/funct values, ALU control codes and datapath mux selects.
package mcycle_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    BNEEX,
    ADDIEX,
    ANDIEX,
    ORIEX,
    IMMWB,
    JEX
  } state_t;

  typedef enum logic [2:0] {
    AOP_ADD,
    AOP_SUB,
    AOP_FUNCT,
    AOP_AND,
    AOP_OR
  } aluop_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // States that talk to memory and therefore may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mcycle_aludec.sv
// ALU decoder: maps the FSM's ALU operation (or the R-type funct field)
// onto the 3-bit alucontrol code and flags funct values it cannot decode.
module mcycle_aludec
  import mcycle_pkg::*;
(
  input  logic [2:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_illegal
);

  always_comb begin
    alucontrol    = ALU_ADD;
    funct_illegal = 1'b0;
    case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_AND: alucontrol = ALU_AND;
      AOP_OR:  alucontrol = ALU_OR;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: funct_illegal = 1'b1;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mcycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait-state handling and a
// saturating counter of illegal-instruction pulses.
module mcycle_ctrl
  import mcycle_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pcen,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             immext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  aluop_t           aluop;
  logic             funct_illegal;
  logic             stall;
  logic             pcwrite, branch, branchn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign stall = (MEM_WAIT != 0) && !mem_ready && is_mem_state(state_q);

  // ALU op depends on state only, keeping it clear of the funct_illegal path.
  always_comb begin
    aluop = AOP_ADD;
    case (state_q)
      RTYPEEX:       aluop = AOP_FUNCT;
      BEQEX, BNEEX:  aluop = AOP_SUB;
      ANDIEX:        aluop = AOP_AND;
      ORIEX:         aluop = AOP_OR;
      default:       aluop = AOP_ADD;
    endcase
  end

  mcycle_aludec u_aludec (
    .aluop         (aluop),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .funct_illegal (funct_illegal)
  );

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    immext   = 1'b0;
    alusrcb  = SRCB_REG;
    pcsrc    = PC_ALU;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchn  = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        if (!stall) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alusrcb = SRCB_BOFS;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_BNE:       state_d = BNEEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_J:         state_d = JEX;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (!stall) state_d = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (!stall) state_d = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        if (funct_illegal) begin
          illegal = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = RTYPEWB;
        end
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = FETCH;
      end
      BEQEX: begin
        alusrca = 1'b1;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
        state_d = FETCH;
      end
      BNEEX: begin
        alusrca = 1'b1;
        pcsrc   = PC_ALUOUT;
        branchn = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = IMMWB;
      end
      ANDIEX, ORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        immext  = 1'b1;
        state_d = IMMWB;
      end
      IMMWB: begin
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JEX: begin
        pcwrite = 1'b1;
        pcsrc   = PC_JUMP;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    pcen = pcwrite | (branch & zero) | (branchn & ~zero);
  end

  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (illegal && (illegal_cnt_q != {CNT_W{1'b1}}))
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Directed bench for mcycle_ctrl: wait-state fetch/load, branches, ori,
// illegal decode, counter saturation and reset during a stalled store.
module tb_mcycle_ctrl;
  import mcycle_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, pcen, memwrite, irwrite, regwrite, alusrca, iord;
  logic       memtoreg, regdst, immext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [7:0] illegal_cnt;

  logic       reset2;
  logic [5:0] op2, funct2;
  logic       zero2, mem_ready2;
  logic       mem_req2, pcen2, memwrite2, irwrite2, regwrite2, alusrca2, iord2;
  logic       memtoreg2, regdst2, immext2, illegal2;
  logic [1:0] alusrcb2, pcsrc2;
  logic [2:0] alucontrol2;
  logic [1:0] illegal_cnt2;

  int checks = 0;
  int errors = 0;
  int irwCount = 0;
  int pcenCount = 0;

  state_t lwStates [10] = '{FETCH, FETCH, FETCH, FETCH, DECODE, MEMADR,
                            MEMRD, MEMRD, MEMRD, MEMWB};
  logic   lwReady  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  mcycle_ctrl #(.MEM_WAIT(1), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .pcen(pcen),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .immext(immext), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  mcycle_ctrl #(.MEM_WAIT(1), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset2), .op(op2), .funct(funct2), .zero(zero2),
    .mem_ready(mem_ready2), .mem_req(mem_req2), .pcen(pcen2),
    .memwrite(memwrite2), .irwrite(irwrite2), .regwrite(regwrite2),
    .alusrca(alusrca2), .iord(iord2), .memtoreg(memtoreg2), .regdst(regdst2),
    .immext(immext2), .alusrcb(alusrcb2), .pcsrc(pcsrc2),
    .alucontrol(alucontrol2), .illegal(illegal2), .illegal_cnt(illegal_cnt2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic mr);
    op = o;
    funct = f;
    zero = z;
    mem_ready = mr;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in the first execute state of the given instruction.
  task automatic fetchDecode(input logic [5:0] o, input logic [5:0] f, input logic z);
    applyStimulus(o, f, z, 1'b1);
    nextCycle();
    applyStimulus(o, f, z, 1'b1);
    nextCycle();
    applyStimulus(o, f, z, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    op2 = 6'b111111;
    funct2 = 6'b000000;
    zero2 = 1'b0;
    mem_ready2 = 1'b1;
    applyStimulus(6'b000000, 6'b000000, 1'b0, 1'b1);
    repeat (2) nextCycle();

    // Narrow counter: an illegal op every FETCH/DECODE pair, five in ten cycles.
    reset2 = 1'b0;
    repeat (4) nextCycle();
    checkOutput("cnt2_after_2", illegal_cnt2, 2);
    repeat (2) nextCycle();
    checkOutput("cnt2_after_3", illegal_cnt2, 3);
    nextCycle();
    checkOutput("cnt2_pulse_saturated", illegal2, 1);
    repeat (3) nextCycle();
    checkOutput("cnt2_after_5", illegal_cnt2, 3);

    // First cycle after reset release, memory not ready.
    reset = 1'b0;
    applyStimulus(OP_LW, 6'b000000, 1'b0, 1'b0);
    checkOutput("rst_state", dut.state_q, FETCH);
    checkOutput("rst_mem_req", mem_req, 1);
    checkOutput("rst_alusrcb", alusrcb, 2'b01);
    checkOutput("rst_alucontrol", alucontrol, 3'b010);
    checkOutput("rst_memwrite", memwrite, 0);
    checkOutput("rst_regwrite", regwrite, 0);
    checkOutput("rst_illegal", illegal, 0);
    checkOutput("rst_cnt", illegal_cnt, 0);

    // lw with 3 wait cycles in FETCH and 2 in MEMRD.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(OP_LW, 6'b000000, 1'b0, lwReady[i]);
      checkOutput($sformatf("lw_state_%0d", i), dut.state_q, lwStates[i]);
      checkOutput($sformatf("lw_irwrite_%0d", i), irwrite, (i == 3) ? 1 : 0);
      checkOutput($sformatf("lw_pcen_%0d", i), pcen, (i == 3) ? 1 : 0);
      checkOutput($sformatf("lw_mem_req_%0d", i), mem_req,
                  (i <= 3 || (i >= 6 && i <= 8)) ? 1 : 0);
      irwCount += int'(irwrite);
      pcenCount += int'(pcen);
      if (i == 5) checkOutput("lw_memadr_alusrcb", alusrcb, 2'b10);
      if (i == 7) checkOutput("lw_memrd_iord", iord, 1);
      if (i == 9) checkOutput("lw_memwb_memtoreg", {regwrite, memtoreg}, 2'b11);
      nextCycle();
    end
    checkOutput("lw_irwrite_once", irwCount, 1);
    checkOutput("lw_pcen_once", pcenCount, 1);
    applyStimulus(OP_BNE, 6'b000000, 1'b0, 1'b1);
    checkOutput("lw_return_fetch", dut.state_q, FETCH);

    // bne taken (zero=0) then not taken (zero=1).
    fetchDecode(OP_BNE, 6'b000000, 1'b0);
    checkOutput("bne0_state", dut.state_q, BNEEX);
    checkOutput("bne0_pcen", pcen, 1);
    checkOutput("bne0_alucontrol", alucontrol, 3'b110);
    checkOutput("bne0_pcsrc", pcsrc, 2'b01);
    nextCycle();
    fetchDecode(OP_BNE, 6'b000000, 1'b1);
    checkOutput("bne1_state", dut.state_q, BNEEX);
    checkOutput("bne1_pcen", pcen, 0);
    nextCycle();
    applyStimulus(OP_ORI, 6'b000000, 1'b0, 1'b1);
    checkOutput("bne_return_fetch", dut.state_q, FETCH);

    // ori: zero-extended OR immediate, then write back to rt.
    fetchDecode(OP_ORI, 6'b000000, 1'b0);
    checkOutput("ori_immext", immext, 1);
    checkOutput("ori_alucontrol", alucontrol, 3'b001);
    checkOutput("ori_alusrcb", alusrcb, 2'b10);
    nextCycle();
    checkOutput("immwb_regwrite", regwrite, 1);
    checkOutput("immwb_regdst", regdst, 0);
    nextCycle();

    // Valid R-type slt.
    fetchDecode(OP_RTYPE, FN_SLT, 1'b0);
    checkOutput("slt_alucontrol", alucontrol, 3'b111);
    checkOutput("slt_illegal", illegal, 0);
    nextCycle();
    checkOutput("rtypewb_regdst", {regwrite, regdst}, 2'b11);
    nextCycle();

    // j: unconditional PC load from the jump target.
    fetchDecode(OP_J, 6'b000000, 1'b1);
    checkOutput("j_pcen", pcen, 1);
    checkOutput("j_pcsrc", pcsrc, 2'b10);
    nextCycle();

    // Illegal opcode then illegal funct.
    applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(6'b111111, 6'b000000, 1'b0, 1'b1);
    checkOutput("illop_pulse", illegal, 1);
    checkOutput("illop_regwrite", regwrite, 0);
    nextCycle();
    checkOutput("illop_next_fetch", dut.state_q, FETCH);
    checkOutput("illop_cnt", illegal_cnt, 1);
    checkOutput("illop_pulse_gone", illegal, 0);
    fetchDecode(OP_RTYPE, 6'b000000, 1'b0);
    checkOutput("illfn_pulse", illegal, 1);
    checkOutput("illfn_regwrite", regwrite, 0);
    nextCycle();
    checkOutput("illfn_next_fetch", dut.state_q, FETCH);
    checkOutput("illfn_cnt", illegal_cnt, 2);
    checkOutput("illfn_fetch_regwrite", regwrite, 0);

    // sw stalled in MEMWR, then reset.
    fetchDecode(OP_SW, 6'b000000, 1'b0);
    checkOutput("sw_memadr", dut.state_q, MEMADR);
    nextCycle();
    applyStimulus(OP_SW, 6'b000000, 1'b0, 1'b0);
    checkOutput("sw_memwr_state", dut.state_q, MEMWR);
    checkOutput("sw_memwrite", memwrite, 1);
    nextCycle();
    applyStimulus(OP_SW, 6'b000000, 1'b0, 1'b0);
    checkOutput("sw_hold_state", dut.state_q, MEMWR);
    checkOutput("sw_hold_memwrite", {mem_req, memwrite}, 2'b11);
    reset = 1'b1;
    nextCycle();
    checkOutput("swrst_memwrite", memwrite, 0);
    checkOutput("swrst_state", dut.state_q, FETCH);
    checkOutput("swrst_cnt", illegal_cnt, 0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
